// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between the core datapath (port 0) and
// a debug/DMA requester (port 1). Requests use a valid/ready handshake and are
// granted round-robin. Port 1 may lock the memory for atomic read-modify-write
// sequences. A lock held for LOCK_MAX cycles is forcibly released so that the
// core cannot starve.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   pX_valid / pX_ready       request handshake per port
//   pX_we, pX_addr, pX_wdata  request contents per port
//   pX_rsp_valid              response for the request accepted last cycle
//   pX_rsp_rdata              read data (0 for writes and when idle)
//   dbg_lock                  port 1 lock request
//   lock_err                  one-cycle pulse on forced lock release
//   mem_e, mem_we, mem_addr,
//   mem_wdata                 memory drive (all 0 when no access)
//   mem_rdata                 memory read data, one cycle after a read
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    input  logic              dbg_lock,
    output logic              lock_err,
    output logic              mem_e,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    typedef enum logic [1:0] {
        ST_ARB,
        ST_LOCKED,
        ST_REL_WAIT
    } state_t;

    state_t           r_state;
    logic             r_last;
    logic [CNT_W-1:0] r_lockCnt;
    logic             r_rspValid;
    logic             r_rspPort;
    logic             r_rspWe;
    logic             r_lockErr;

    logic w_acc0;
    logic w_acc1;

    // Grant logic. r_last names the most recently accepted port, so on a tie
    // the other port wins. Ready is forced low during reset so every output
    // is quiet the moment reset is asserted.
    always_comb begin
        p0_ready = 1'b0;
        p1_ready = 1'b0;
        if (!rst) begin
            if (r_state == ST_LOCKED) begin
                p1_ready = p1_valid;
            end else begin
                p0_ready = p0_valid & (~p1_valid | r_last);
                p1_ready = p1_valid & (~p0_valid | ~r_last);
            end
        end
    end

    assign w_acc0 = p0_valid & p0_ready;
    assign w_acc1 = p1_valid & p1_ready;

    // Memory drive is muxed from the winner and held at zero when idle.
    always_comb begin
        mem_e     = w_acc0 | w_acc1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_acc0) begin
            mem_we    = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (w_acc1) begin
            mem_we    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end
    end

    // Responses come from the registered tag; read data passes straight
    // through from the memory, which has one cycle of latency.
    assign p0_rsp_valid = r_rspValid & ~r_rspPort;
    assign p1_rsp_valid = r_rspValid &  r_rspPort;
    assign p0_rsp_rdata = (p0_rsp_valid & ~r_rspWe) ? mem_rdata : '0;
    assign p1_rsp_rdata = (p1_rsp_valid & ~r_rspWe) ? mem_rdata : '0;
    assign lock_err     = r_lockErr;

    // Arbitration state, lock counter and response tag. A forced release
    // hands priority to port 0 by marking port 1 as last, and the REL_WAIT
    // state refuses a new lock until dbg_lock has been seen low once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_ARB;
            r_last     <= 1'b1;
            r_lockCnt  <= '0;
            r_rspValid <= 1'b0;
            r_rspPort  <= 1'b0;
            r_rspWe    <= 1'b0;
            r_lockErr  <= 1'b0;
        end else begin
            r_lockErr  <= 1'b0;
            r_rspValid <= w_acc0 | w_acc1;
            r_rspPort  <= w_acc1;
            r_rspWe    <= mem_we;
            if (w_acc0) begin
                r_last <= 1'b0;
            end else if (w_acc1) begin
                r_last <= 1'b1;
            end
            case (r_state)
                ST_ARB: begin
                    if (w_acc1 && dbg_lock) begin
                        r_state   <= ST_LOCKED;
                        r_lockCnt <= CNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!dbg_lock) begin
                        r_state   <= ST_ARB;
                        r_lockCnt <= '0;
                    end else if (r_lockCnt >= CNT_MAX) begin
                        r_state   <= ST_REL_WAIT;
                        r_lockCnt <= '0;
                        r_lockErr <= 1'b1;
                        r_last    <= 1'b1;
                    end else begin
                        r_lockCnt <= r_lockCnt + CNT_W'(1);
                    end
                end
                ST_REL_WAIT: begin
                    if (!dbg_lock) begin
                        r_state <= ST_ARB;
                    end
                end
                default: begin
                    r_state   <= ST_ARB;
                    r_lockCnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Bench for dmem_arbiter with LOCK_MAX = 4 and a behavioural 16x8 memory
// (one-cycle read latency). Directed scenarios cover reset, contention,
// write/read, back-to-back, locking, lock timeout and idle; a randomized run
// is compared against a reference model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int LOCK_MAX = 4;

    logic       clk;
    logic       rst;
    logic       p0_valid, p1_valid;
    logic       p0_ready, p1_ready;
    logic       p0_we, p1_we;
    logic [3:0] p0_addr, p1_addr;
    logic [7:0] p0_wdata, p1_wdata;
    logic       p0_rsp_valid, p1_rsp_valid;
    logic [7:0] p0_rsp_rdata, p1_rsp_rdata;
    logic       dbg_lock;
    logic       lock_err;
    logic       mem_e, mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic [7:0] ram [16];

    int checkCount = 0;
    int passCount  = 0;

    dmem_arbiter #(.ADDR_W(4), .DATA_W(8), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
        .dbg_lock(dbg_lock), .lock_err(lock_err),
        .mem_e(mem_e), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory with registered read data.
    always @(posedge clk) begin
        if (mem_e) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        p0_valid = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_valid = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        dbg_lock = 0;
    endtask

    task automatic writeWord(input int port, input logic [3:0] addr, input logic [7:0] data);
        nextCycle();
        clearInputs();
        if (port == 0) begin
            p0_valid = 1; p0_we = 1; p0_addr = addr; p0_wdata = data;
        end else begin
            p1_valid = 1; p1_we = 1; p1_addr = addr; p1_wdata = data;
        end
        #2;
        checkCount++;
        if (((port == 0) ? p0_ready : p1_ready) !== 1'b1)
            $display("[TB] FAIL preload_accept port %0d: ready got 0 expected 1", port);
        else passCount++;
    endtask

    task automatic test_reset();
        logic [34:0] allOut;
        nextCycle();
        rst = 0;
        clearInputs();
        p0_valid = 1; p0_addr = 4'd0;
        p1_valid = 1; p1_addr = 4'd1;
        #2;
        checkCount++;
        if ({p0_ready, p1_ready} !== 2'b10)
            $display("[TB] FAIL reset_first_tie: got %b expected 10", {p0_ready, p1_ready});
        else passCount++;
        nextCycle();
        #2;
        checkCount++;
        if ({p0_rsp_valid, p1_ready} !== 2'b11)
            $display("[TB] FAIL reset_pre_state: got %b expected 11", {p0_rsp_valid, p1_ready});
        else passCount++;
        #1 rst = 1;
        #1;
        allOut = {p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_rdata, p1_rsp_rdata,
                  mem_e, mem_we, mem_addr, mem_wdata, lock_err};
        checkCount++;
        if (allOut !== 35'd0)
            $display("[TB] FAIL reset_async_clear: got %h expected 0", allOut);
        else passCount++;
        nextCycle();
        allOut = {p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_rdata, p1_rsp_rdata,
                  mem_e, mem_we, mem_addr, mem_wdata, lock_err};
        checkCount++;
        if (allOut !== 35'd0)
            $display("[TB] FAIL reset_held: got %h expected 0", allOut);
        else passCount++;
        rst = 0;
        #2;
        checkCount++;
        if ({p0_ready, p1_ready} !== 2'b10)
            $display("[TB] FAIL reset_release_tie: got %b expected 10", {p0_ready, p1_ready});
        else passCount++;
    endtask

    task automatic test_contention();
        logic [1:0] expGrant;
        writeWord(0, 4'd3, 8'h3C);
        writeWord(1, 4'd5, 8'hA5);
        for (int i = 0; i < 7; i++) begin
            nextCycle();
            clearInputs();
            if (i < 6) begin
                p0_valid = 1; p0_addr = 4'd3;
                p1_valid = 1; p1_addr = 4'd5;
            end
            #2;
            if (i < 6) begin
                expGrant = (i % 2 == 0) ? 2'b10 : 2'b01;
                checkCount++;
                if ({p0_ready, p1_ready} !== expGrant)
                    $display("[TB] FAIL contention_grant %0d: got %b expected %b", i, {p0_ready, p1_ready}, expGrant);
                else passCount++;
            end
            if (i > 0) begin
                checkCount++;
                if (i % 2 == 1) begin
                    if ({p0_rsp_valid, p0_rsp_rdata, p1_rsp_valid} !== {1'b1, 8'h3C, 1'b0})
                        $display("[TB] FAIL contention_rsp0 %0d: got %b/%h expected 1/3c", i, p0_rsp_valid, p0_rsp_rdata);
                    else passCount++;
                end else begin
                    if ({p1_rsp_valid, p1_rsp_rdata, p0_rsp_valid} !== {1'b1, 8'hA5, 1'b0})
                        $display("[TB] FAIL contention_rsp1 %0d: got %b/%h expected 1/a5", i, p1_rsp_valid, p1_rsp_rdata);
                    else passCount++;
                end
            end
        end
    endtask

    task automatic test_write_read();
        nextCycle();
        clearInputs();
        p0_valid = 1; p0_we = 1; p0_addr = 4'd9; p0_wdata = 8'h7E;
        nextCycle();
        clearInputs();
        p0_valid = 1; p0_addr = 4'd9;
        #2;
        checkCount++;
        if ({p0_ready, p0_rsp_valid, p0_rsp_rdata} !== {1'b1, 1'b1, 8'h00})
            $display("[TB] FAIL write_rsp: got %b/%b/%h expected 1/1/00", p0_ready, p0_rsp_valid, p0_rsp_rdata);
        else passCount++;
        nextCycle();
        clearInputs();
        #2;
        checkCount++;
        if ({p0_rsp_valid, p0_rsp_rdata} !== {1'b1, 8'h7E})
            $display("[TB] FAIL read_after_write: got %b/%h expected 1/7e", p0_rsp_valid, p0_rsp_rdata);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        nextCycle();
        clearInputs();
        p0_valid = 1; p0_addr = 4'd3;
        nextCycle();
        clearInputs();
        p0_valid = 1; p0_we = 1; p0_addr = 4'd3; p0_wdata = 8'h11;
        #2;
        checkCount++;
        if ({p0_ready, p0_rsp_valid, p0_rsp_rdata} !== {1'b1, 1'b1, 8'h3C})
            $display("[TB] FAIL b2b_old_data: got %b/%b/%h expected 1/1/3c", p0_ready, p0_rsp_valid, p0_rsp_rdata);
        else passCount++;
        nextCycle();
        clearInputs();
        p0_valid = 1; p0_addr = 4'd3;
        #2;
        checkCount++;
        if ({p0_rsp_valid, p0_rsp_rdata} !== {1'b1, 8'h00})
            $display("[TB] FAIL b2b_write_rsp: got %b/%h expected 1/00", p0_rsp_valid, p0_rsp_rdata);
        else passCount++;
        nextCycle();
        clearInputs();
        #2;
        checkCount++;
        if ({p0_rsp_valid, p0_rsp_rdata} !== {1'b1, 8'h11})
            $display("[TB] FAIL b2b_new_data: got %b/%h expected 1/11", p0_rsp_valid, p0_rsp_rdata);
        else passCount++;
    endtask

    task automatic test_lock();
        nextCycle();
        clearInputs();
        p0_valid = 1; p1_valid = 1; p1_addr = 4'd2; dbg_lock = 1;
        #2;
        checkCount++;
        if ({p0_ready, p1_ready} !== 2'b01)
            $display("[TB] FAIL lock_take: got %b expected 01", {p0_ready, p1_ready});
        else passCount++;
        nextCycle();
        clearInputs();
        p0_valid = 1; dbg_lock = 1;
        #2;
        checkCount++;
        if ({p0_ready, p1_rsp_valid} !== 2'b01)
            $display("[TB] FAIL lock_hold: got %b expected 01", {p0_ready, p1_rsp_valid});
        else passCount++;
        nextCycle();
        clearInputs();
        p0_valid = 1; p1_valid = 1; p1_we = 1; p1_addr = 4'd2; p1_wdata = 8'h55; dbg_lock = 1;
        #2;
        checkCount++;
        if ({p0_ready, p1_ready} !== 2'b01)
            $display("[TB] FAIL lock_write: got %b expected 01", {p0_ready, p1_ready});
        else passCount++;
        nextCycle();
        clearInputs();
        p0_valid = 1;
        #2;
        checkCount++;
        if ({p0_ready, p1_rsp_valid, p1_rsp_rdata} !== {1'b0, 1'b1, 8'h00})
            $display("[TB] FAIL lock_fall_cycle: got %b/%b/%h expected 0/1/00", p0_ready, p1_rsp_valid, p1_rsp_rdata);
        else passCount++;
        nextCycle();
        clearInputs();
        p0_valid = 1;
        #2;
        checkCount++;
        if (p0_ready !== 1'b1)
            $display("[TB] FAIL lock_released: got %b expected 1", p0_ready);
        else passCount++;
    endtask

    task automatic test_lock_timeout();
        nextCycle();
        clearInputs();
        p0_valid = 1; p1_valid = 1; dbg_lock = 1;
        #2;
        checkCount++;
        if (p1_ready !== 1'b1)
            $display("[TB] FAIL timeout_take: got %b expected 1", p1_ready);
        else passCount++;
        for (int i = 1; i <= LOCK_MAX + 1; i++) begin
            nextCycle();
            clearInputs();
            p0_valid = 1; dbg_lock = 1;
            #2;
            checkCount++;
            if (i <= LOCK_MAX) begin
                if ({p0_ready, lock_err} !== 2'b00)
                    $display("[TB] FAIL timeout_locked %0d: got %b expected 00", i, {p0_ready, lock_err});
                else passCount++;
            end else begin
                if ({p0_ready, lock_err} !== 2'b11)
                    $display("[TB] FAIL timeout_release: got %b expected 11", {p0_ready, lock_err});
                else passCount++;
            end
        end
        nextCycle();
        clearInputs();
        p1_valid = 1; dbg_lock = 1;
        #2;
        checkCount++;
        if ({p1_ready, lock_err} !== 2'b10)
            $display("[TB] FAIL relwait_p1: got %b expected 10", {p1_ready, lock_err});
        else passCount++;
        nextCycle();
        clearInputs();
        p0_valid = 1; dbg_lock = 1;
        #2;
        checkCount++;
        if (p0_ready !== 1'b1)
            $display("[TB] FAIL relwait_no_relock: got %b expected 1", p0_ready);
        else passCount++;
        nextCycle();
        clearInputs();
        nextCycle();
        clearInputs();
        p1_valid = 1; dbg_lock = 1;
        nextCycle();
        clearInputs();
        p0_valid = 1; dbg_lock = 1;
        #2;
        checkCount++;
        if (p0_ready !== 1'b0)
            $display("[TB] FAIL relock_after_low: got %b expected 0", p0_ready);
        else passCount++;
        nextCycle();
        clearInputs();
        p0_valid = 1;
        nextCycle();
        clearInputs();
        p0_valid = 1;
        #2;
        checkCount++;
        if (p0_ready !== 1'b1)
            $display("[TB] FAIL relock_release: got %b expected 1", p0_ready);
        else passCount++;
    endtask

    task automatic test_idle();
        nextCycle();
        clearInputs();
        p0_valid = 1; p0_addr = 4'd0;
        for (int i = 0; i < 10; i++) begin
            nextCycle();
            clearInputs();
            #2;
            checkCount++;
            if ({mem_e, mem_we, mem_addr, mem_wdata} !== 14'd0)
                $display("[TB] FAIL idle_mem %0d: got %h expected 0", i, {mem_e, mem_we, mem_addr, mem_wdata});
            else passCount++;
            if (i > 0) begin
                checkCount++;
                if ({p0_rsp_valid, p0_rsp_rdata, p1_rsp_valid, p1_rsp_rdata} !== 18'd0)
                    $display("[TB] FAIL idle_rsp %0d: got %h expected 0", i,
                             {p0_rsp_valid, p0_rsp_rdata, p1_rsp_valid, p1_rsp_rdata});
                else passCount++;
            end
        end
        nextCycle();
        clearInputs();
        p0_valid = 1; p1_valid = 1;
        #2;
        checkCount++;
        if ({p0_ready, p1_ready} !== 2'b01)
            $display("[TB] FAIL idle_last_kept: got %b expected 01", {p0_ready, p1_ready});
        else passCount++;
    endtask

    task automatic test_random();
        int         mLast;
        bit         mLocked;
        bit         mRelWait;
        int         mAge;
        bit         mLockErr;
        bit         rspV;
        int         rspPort;
        logic [7:0] rspData;
        logic [7:0] refMem [16];
        bit         dbg;
        bit         e0, e1;
        int         win;
        logic       wWe;
        logic [3:0] wAddr;
        logic [7:0] wData;
        logic [13:0] expBus;
        logic [17:0] expRsp;
        nextCycle();
        rst = 1;
        clearInputs();
        nextCycle();
        rst = 0;
        mLast = 1; mLocked = 0; mRelWait = 0; mAge = 0; mLockErr = 0;
        rspV = 0; rspPort = 0; rspData = 8'h00; dbg = 0;
        for (int i = 0; i < 16; i++) refMem[i] = 8'h00;
        for (int cyc = 0; cyc < 416; cyc++) begin
            nextCycle();
            clearInputs();
            if (cyc < 16) begin
                p0_valid = 1; p0_we = 1; p0_addr = cyc[3:0]; p0_wdata = 8'($urandom);
            end else begin
                if ($urandom_range(0, 7) == 0) dbg = !dbg;
                p0_valid = ($urandom_range(0, 9) < 7);
                p1_valid = ($urandom_range(0, 9) < 7);
                p0_we = 1'($urandom); p1_we = 1'($urandom);
                p0_addr = 4'($urandom); p1_addr = 4'($urandom);
                p0_wdata = 8'($urandom); p1_wdata = 8'($urandom);
                dbg_lock = dbg;
            end
            #2;
            if (mLocked) begin
                e0 = 0; e1 = p1_valid;
            end else if (p0_valid && p1_valid) begin
                e0 = (mLast == 1); e1 = (mLast == 0);
            end else begin
                e0 = p0_valid; e1 = p1_valid;
            end
            win = e0 ? 0 : (e1 ? 1 : -1);
            wWe   = (win == 1) ? p1_we    : p0_we;
            wAddr = (win == 1) ? p1_addr  : p0_addr;
            wData = (win == 1) ? p1_wdata : p0_wdata;
            expBus = (win >= 0) ? {1'b1, wWe, wAddr, wData} : 14'd0;
            expRsp = {rspV && rspPort == 0, (rspV && rspPort == 0) ? rspData : 8'h00,
                      rspV && rspPort == 1, (rspV && rspPort == 1) ? rspData : 8'h00};
            checkCount++;
            if ({p0_ready, p1_ready} !== {e0, e1})
                $display("[TB] FAIL rand_grant cyc %0d: got %b expected %b", cyc, {p0_ready, p1_ready}, {e0, e1});
            else passCount++;
            checkCount++;
            if ({mem_e, mem_we, mem_addr, mem_wdata} !== expBus)
                $display("[TB] FAIL rand_mem cyc %0d: got %h expected %h", cyc, {mem_e, mem_we, mem_addr, mem_wdata}, expBus);
            else passCount++;
            checkCount++;
            if ({p0_rsp_valid, p0_rsp_rdata, p1_rsp_valid, p1_rsp_rdata} !== expRsp)
                $display("[TB] FAIL rand_rsp cyc %0d: got %h expected %h", cyc,
                         {p0_rsp_valid, p0_rsp_rdata, p1_rsp_valid, p1_rsp_rdata}, expRsp);
            else passCount++;
            checkCount++;
            if (lock_err !== mLockErr)
                $display("[TB] FAIL rand_lock_err cyc %0d: got %b expected %b", cyc, lock_err, mLockErr);
            else passCount++;
            // Advance the reference to the state after this cycle's edge.
            mLockErr = 0;
            if (win >= 0) begin
                rspV = 1; rspPort = win;
                rspData = wWe ? 8'h00 : refMem[wAddr];
                if (wWe) refMem[wAddr] = wData;
                mLast = win;
            end else begin
                rspV = 0;
            end
            if (mLocked) begin
                if (!dbg_lock) mLocked = 0;
                else if (mAge >= LOCK_MAX) begin
                    mLocked = 0; mRelWait = 1; mLockErr = 1; mLast = 1;
                end else mAge++;
            end else if (mRelWait) begin
                if (!dbg_lock) mRelWait = 0;
            end else if (win == 1 && dbg_lock) begin
                mLocked = 1; mAge = 1;
            end
        end
        nextCycle();
        clearInputs();
    endtask

    initial begin
        rst = 1;
        clearInputs();
        test_reset();
        test_contention();
        test_write_read();
        test_back_to_back();
        test_lock();
        test_lock_timeout();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port 16×8 data memory between the core datapath (port 0) and a debug/DMA requester (port 1). Performs round-robin arbitration on a valid/ready handshake, drives the memory's enable, write-enable, address and data, and routes the one-cycle-latency read data back to the winning port. Port 1 can lock the memory for atomic read-modify-write sequences; a bounded lock timeout prevents the core from starving.

## Interface
- `ADDR_W`, default 4: data memory address width.
- `DATA_W`, default 8: data width.
- `LOCK_MAX`, default 16: maximum number of consecutive cycles port 1 may hold the lock.

- `clk` input 1: clock, rising-edge.
- `rst` input 1: reset, asynchronous, active-high.
- `p0_valid`, `p1_valid` input 1: request valid, per port.
- `p0_ready`, `p1_ready` output 1: request accepted this cycle, per port.
- `p0_we`, `p1_we` input 1: 1 = write, 0 = read.
- `p0_addr`, `p1_addr` input ADDR_W: word address.
- `p0_wdata`, `p1_wdata` input DATA_W: write data.
- `p0_rsp_valid`, `p1_rsp_valid` output 1: response for the request accepted in the previous cycle.
- `p0_rsp_rdata`, `p1_rsp_rdata` output DATA_W: read data. Equals 0 for write responses and when the port has no response.
- `dbg_lock` input 1: port 1 lock request.
- `lock_err` output 1: one-cycle pulse when the lock is forcibly released.
- `mem_e`, `mem_we` output 1: memory enable and write enable.
- `mem_addr` output ADDR_W, `mem_wdata` output DATA_W: memory address and write data.
- `mem_rdata` input DATA_W: memory read data, valid the cycle after `mem_e` with `mem_we` = 0.

## Operation
- **Acceptance.** A request is accepted when `pX_valid && pX_ready`. At most one port is ready per cycle. Ready is combinational from the valid inputs and the registered state.
- **Memory drive.** `mem_e` equals the OR of the accept conditions. `mem_we`, `mem_addr` and `mem_wdata` are muxed from the winning port. When `mem_e` = 0, all of them are 0.
- **Round-robin.** Register `last` holds the most recently accepted port.
  - Only one port valid: that port wins.
  - Both ports valid: the port ≠ `last` wins.
  - `last` updates only on acceptance.
- **Responses.** Every accepted request, read or write, produces `pX_rsp_valid` = 1 in the next cycle, from a registered winner/valid/we tag.
  - Read: `pX_rsp_rdata` = `mem_rdata`, passed through combinationally.
  - Write: `pX_rsp_rdata` = 0.
- **State machine.**
  - **ARB:** normal arbitration. Moves to LOCKED when port 1 is accepted with `dbg_lock` = 1. The lock counter loads 1.
  - **LOCKED:** `p0_ready` = 0. Port 1 is ready whenever it is valid. The lock counter increments every cycle.
    - `dbg_lock` = 0 at a clock edge: go to ARB.
    - Counter reaches `LOCK_MAX` with `dbg_lock` still 1: pulse `lock_err`, set `last` = 1, go to REL_WAIT.
  - **REL_WAIT:** arbitrates like ARB, but `dbg_lock` is ignored, so no new lock can be taken. Moves to ARB at the edge where `dbg_lock` = 0.
- **Lock release.** The lock is released at the edge where `dbg_lock` is sampled low. In the cycle `dbg_lock` falls, port 0 is still blocked, because the state is registered.

## Timing
- **Reset values.** All `pX_ready`, `mem_*`, `pX_rsp_valid`, `pX_rsp_rdata` and `lock_err` outputs are 0. State = ARB, `last` = 1 (port 0 wins the first tie), lock counter = 0, response tag cleared.
- **Latency.** Grant is in the same cycle as valid, zero wait when uncontested. Response arrives exactly one cycle after acceptance. Sustained throughput is one access per cycle.
- **Contested fairness.** With both ports continuously valid in ARB, grants alternate 0,1,0,1… A port waits at most 1 cycle in ARB or REL_WAIT, and at most `LOCK_MAX` + 1 cycles while a lock is active.
- **Reset mid-operation.** Reset asserted mid-operation drops a pending response: `rsp_valid` goes to 0 immediately and asynchronously. A locked state is abandoned with no `lock_err` pulse.
- **Back-to-back traffic.** A read accepted in cycle N and a write to the same address accepted in cycle N+1 are legal. The read response in N+1 carries the old data.
- **Lock counter width.** $clog2(`LOCK_MAX`+1). It saturates and never wraps. The counter is held at 0 outside LOCKED.
- **Ignored inputs.** `dbg_lock` is ignored when `p1_valid` is not accepted in ARB. `dbg_lock` alone never grants.

## Test plan
- **Reset.** Assert `rst` mid-cycle with both ports valid → all outputs 0 immediately. After release, both valid → `p0_ready` = 1 first.
- **Contention.** `p0_valid` = `p1_valid` = 1 for 6 cycles, with reads to addresses 3 and 5 respectively, after memory is preloaded with 0x3C at address 3 and 0xA5 at address 5 → grants 0,1,0,1,0,1. `p0_rsp_rdata` = 0x3C and `p1_rsp_rdata` = 0xA5, each one cycle after its grant.
- **Write then read.** Port 0 writes 0x7E to address 9, then reads address 9 the next cycle → `p0_rsp_valid` on both cycles. `rdata` = 0x00 for the write and 0x7E for the read.
- **Atomic lock.** Port 1 reads address 2 with `dbg_lock` = 1, then writes address 2 two cycles later, then drops `dbg_lock`; port 0 is valid throughout → `p0_ready` = 0 until the edge after `dbg_lock` falls, then 1.
- **Lock timeout.** `LOCK_MAX` = 4, `dbg_lock` held high → `lock_err` pulses once, 4 cycles after the lock is taken. Port 0 is granted the next cycle. No relock occurs until `dbg_lock` has been low for one edge.
- **Idle.** Neither port valid for 10 cycles → `mem_e` = 0, all responses 0, `last` unchanged.
